waveform_capture: RTL

//  Triggered sample store between the ADC sample source and the VGA display stage.

---
 rtl/wfm_pkg.sv | 22 ++
 rtl/wfm_dpram.sv | 43 ++++
 rtl/waveform_capture.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/wfm_pkg.sv
// Shared types and defaults for the waveform capture block.
// Optional feature macro used by the top level: WFM_AUTO_TRIG_EN.
package wfm_pkg;

   localparam int DEFAULT_SAMPLE_W     = 8;
   localparam int DEFAULT_DEPTH        = 640;
   localparam int DEFAULT_ADDR_W       = 10;
   localparam int DEFAULT_AUTO_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      ARMED   = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2,
      STOPPED = 2'd3
   } state_e;

   localparam logic [1:0] MODE_AUTO   = 2'b00;
   localparam logic [1:0] MODE_NORMAL = 2'b01;
   localparam logic [1:0] MODE_SINGLE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/wfm_dpram.sv
// Two-bank sample store: one write port, one registered read port.
// Address MSB selects the bank, the low bits select the column.
module wfm_dpram #(
   parameter int SAMPLE_W = 8,
   parameter int DEPTH    = 640,
   parameter int ADDR_W   = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                we_i,
   input  logic [ADDR_W:0]     wr_addr_i,
   input  logic [SAMPLE_W-1:0] wr_data_i,
   input  logic [ADDR_W:0]     rd_addr_i,
   input  logic                rd_zero_i,
   output logic [SAMPLE_W-1:0] rd_data_o
);

   logic [SAMPLE_W-1:0] mem_q [2][DEPTH];
   logic [SAMPLE_W-1:0] rd_data_q;

   // Sample write into the addressed bank.
   // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
   always_ff @(posedge clk_i) begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      if (we_i) begin
         mem_q[wr_addr_i[ADDR_W]][wr_addr_i[ADDR_W-1:0]] <= wr_data_i;
      end
   end

   // Registered read; out-of-range columns return zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (rd_zero_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_addr_i[ADDR_W]][rd_addr_i[ADDR_W-1:0]];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/waveform_capture.sv
// Triggered, decimated, double-buffered sample capture for the display path.
// Define WFM_AUTO_TRIG_EN to build the auto-trigger timeout used in mode 00.
module waveform_capture
   import wfm_pkg::*;
#(
   parameter int SAMPLE_W     = DEFAULT_SAMPLE_W,
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int ADDR_W       = DEFAULT_ADDR_W,
   parameter int AUTO_TIMEOUT = DEFAULT_AUTO_TIMEOUT
) (
   input  logic                clk_25MHz,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic [3:0]          decim,
   input  logic [SAMPLE_W-1:0] trig_level,
   input  logic                trig_slope,
   input  logic [1:0]          mode,
   input  logic                arm,
   input  logic                vblank,
   input  logic [ADDR_W-1:0]   rd_col,
   output logic [SAMPLE_W-1:0] rd_data,
   output logic                frame_ready,
   output logic                triggered,
   output logic                busy
);

   state_e              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic                front_q;
   logic                frame_ready_q;
   logic [3:0]          dcnt_q, dcnt_d;
   logic [SAMPLE_W-1:0] prev_q;
   logic [ADDR_W-1:0]   wr_col_q, wr_col_d, wr_col;
   logic                wr_en, swap, accept, trig_hit, auto_fire;

   assign accept   = sample_valid && (dcnt_q == 4'd0);
   assign trig_hit = accept && (trig_slope ? (prev_q > trig_level && sample_in <= trig_level)
                                           : (prev_q < trig_level && sample_in >= trig_level));

   // Decimation phase: advances on valid samples only, wraps after reaching decim.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      dcnt_d = dcnt_q;
      if (sample_valid) begin
         dcnt_d = (dcnt_q >= decim) ? 4'd0 : dcnt_q + 4'd1;
      end
   end

`ifdef WFM_AUTO_TRIG_EN
   localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Timeout count of accepted samples while armed in auto mode; cleared on entry to ARMED.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_d == ARMED && state_q != ARMED) begin
         to_cnt_d = '0;
      end else if (state_q == ARMED && mode_q == MODE_AUTO && accept) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk_25MHz) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end

   assign auto_fire = (state_q == ARMED) && (mode_q == MODE_AUTO) && accept &&
                      (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
`else
   assign auto_fire = 1'b0;
`endif

   // Next state, write strobe/column and bank swap request.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      wr_col_d = wr_col_q;
      wr_col   = '0;
      wr_en    = 1'b0;
      swap     = 1'b0;
      case (state_q)
         ARMED: begin
            if (mode_q != MODE_HOLD && (trig_hit || auto_fire)) begin
               state_d  = CAPTURE;
               wr_en    = 1'b1;
               wr_col   = '0;
               wr_col_d = '0;
            end
         end
         CAPTURE: begin
            if (accept) begin
               wr_en    = 1'b1;
               wr_col   = wr_col_q + ADDR_W'(1);
               wr_col_d = wr_col;
               if (wr_col == ADDR_W'(DEPTH - 1)) state_d = DONE;
            end
         end
         DONE: begin
            if (vblank) begin
               swap = 1'b1;
               if (mode_q == MODE_SINGLE) begin
                  state_d = STOPPED;
               end else begin
                  state_d = ARMED;
                  mode_d  = mode;
               end
            end
         end
         STOPPED: begin
            if (arm) begin
               state_d = ARMED;
               mode_d  = mode;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   // State, mode latch, bank select, decimator and trigger history registers.
   // The mode is sampled on every entry to ARMED, reset included.
   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         state_q       <= ARMED;
         mode_q        <= mode;
         front_q       <= 1'b0;
         frame_ready_q <= 1'b0;
         dcnt_q        <= '0;
         prev_q        <= '0;
         wr_col_q      <= '0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         front_q       <= front_q ^ swap;
         frame_ready_q <= swap;
         dcnt_q        <= dcnt_d;
         wr_col_q      <= wr_col_d;
         if (accept) prev_q <= sample_in;
      end
   end

   // Writes target the back bank; reads use the front bank as it was before any swap this cycle.
   wfm_dpram #(
      .SAMPLE_W (SAMPLE_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W)
   ) u_ram (
      .clk_i     (clk_25MHz),
      .rst_i     (rst),
      .we_i      (wr_en),
      .wr_addr_i ({~front_q, wr_col}),
      .wr_data_i (sample_in),
      .rd_addr_i ({front_q, rd_col}),
      .rd_zero_i (rd_col >= ADDR_W'(DEPTH)),
      .rd_data_o (rd_data)
   );

   assign frame_ready = frame_ready_q;
   assign triggered   = (state_q == CAPTURE);
   assign busy        = (state_q == CAPTURE) || (state_q == DONE);

endmodule
